rf_read_sched: RTL

Sequencing controller for the single-read-port, single-write-port register file in the NPC core. Accepts decoded operand requests (rs1, rs2, rd) with a valid/ready handshake, time-multiplexes the one read port to fetch both source operands, and presents them together downstream. It owns the register file write port, passes writeback through, and forwards same-cycle writeback data into operand capture. An optional scoreboard stalls requests whose sources or destination have a write still in flight.

---
 rtl/rf_pkg.sv | 17 +
 rtl/rf_read_sched_if.sv | 55 +++++
 rtl/rf_scoreboard.sv | 43 ++++
 rtl/rf_read_sched.sv | 120 ++++++++++++
 4 files changed

// File: rtl/rf_pkg.sv
// rf_pkg: shared types and defaults for the register-file read sequencer.
// Holds the sequencer state encoding and the default address/data widths.
// NREGS is derived from the default address width.
package rf_pkg;

  localparam int ADDR_WIDTH_DEF = 5;
  localparam int DATA_WIDTH_DEF = 32;
  localparam int NREGS          = 2 ** ADDR_WIDTH_DEF;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RD1  = 2'd1,
    RD2  = 2'd2,
    RESP = 2'd3
  } state_t;

endpackage

// File: rtl/rf_read_sched_if.sv
// rf_read_sched_if: request, operand, writeback and register-file port bundle.
// slave is the sequencer side; master is the decoder/downstream/regfile side.
// All signals are single-clock, sampled on the sequencer clock.
interface rf_read_sched_if
  import rf_pkg::*;
#(
  parameter int ADDR_WIDTH = ADDR_WIDTH_DEF,
  parameter int DATA_WIDTH = DATA_WIDTH_DEF
);

  logic                  req_valid;
  logic                  req_ready;
  logic [ADDR_WIDTH-1:0] req_rs1;
  logic [ADDR_WIDTH-1:0] req_rs2;
  logic [ADDR_WIDTH-1:0] req_rd;
  logic                  req_rd_wen;

  logic                  out_valid;
  logic                  out_ready;
  logic [DATA_WIDTH-1:0] out_rs1_data;
  logic [DATA_WIDTH-1:0] out_rs2_data;

  logic                  wb_en;
  logic [ADDR_WIDTH-1:0] wb_addr;
  logic [DATA_WIDTH-1:0] wb_data;

  logic [ADDR_WIDTH-1:0] rf_raddr;
  logic [DATA_WIDTH-1:0] rf_rdata;
  logic                  rf_wen;
  logic [ADDR_WIDTH-1:0] rf_waddr;
  logic [DATA_WIDTH-1:0] rf_wdata;

  modport slave (
    input  req_valid, req_rs1, req_rs2, req_rd, req_rd_wen,
    output req_ready,
    output out_valid, out_rs1_data, out_rs2_data,
    input  out_ready,
    input  wb_en, wb_addr, wb_data,
    output rf_raddr,
    input  rf_rdata,
    output rf_wen, rf_waddr, rf_wdata
  );

  modport master (
    output req_valid, req_rs1, req_rs2, req_rd, req_rd_wen,
    input  req_ready,
    input  out_valid, out_rs1_data, out_rs2_data,
    output out_ready,
    output wb_en, wb_addr, wb_data,
    input  rf_raddr,
    output rf_rdata,
    input  rf_wen, rf_waddr, rf_wdata
  );

endinterface

// File: rtl/rf_scoreboard.sv
// rf_scoreboard: per-register busy bits for destinations with a write in flight.
// Latency: set/clear take effect the cycle after; hazard is combinational on the registered bits.
// Backpressure: hazard is used by the sequencer to hold off req_ready; no handshake of its own.
module rf_scoreboard
  import rf_pkg::*;
#(
  parameter int ADDR_WIDTH = ADDR_WIDTH_DEF,
  parameter int NREGS_P    = 2 ** ADDR_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  set_en,
  input  logic [ADDR_WIDTH-1:0] set_addr,
  input  logic                  clr_en,
  input  logic [ADDR_WIDTH-1:0] clr_addr,
  input  logic [ADDR_WIDTH-1:0] chk_rs1,
  input  logic [ADDR_WIDTH-1:0] chk_rs2,
  input  logic [ADDR_WIDTH-1:0] chk_rd,
  input  logic                  chk_rd_wen,
  output logic                  hazard
);

  logic [NREGS_P-1:0] busy_q;
  logic [NREGS_P-1:0] busy_d;

  // Clear from writeback first so that a same-cycle set of the same bit wins; x0 never busy.
  always_comb begin
    busy_d = busy_q;
    if (clr_en) busy_d[clr_addr] = 1'b0;
    if (set_en) busy_d[set_addr] = 1'b1;
    busy_d[0] = 1'b0;
  end

  // Busy vector register.
  always_ff @(posedge clk) begin
    if (rst) busy_q <= '0;
    else     busy_q <= busy_d;
  end

  // Check against the registered vector only: a clear this cycle unblocks next cycle.
  assign hazard = busy_q[chk_rs1] | busy_q[chk_rs2] | (chk_rd_wen & busy_q[chk_rd]);

endmodule

// File: rtl/rf_read_sched.sv
// rf_read_sched: reads rs1 then rs2 over one RF read port, forwards same-cycle writeback, owns RF write port.
// Latency: out_valid 3 cycles after accept (2 when rs1==rs2); next accept the cycle after out handshake.
// Backpressure: req_ready only in IDLE (RF_SCOREBOARD_EN also blocks on busy regs); RESP holds until out_ready.
module rf_read_sched
  import rf_pkg::*;
#(
  parameter int ADDR_WIDTH = ADDR_WIDTH_DEF,
  parameter int DATA_WIDTH = DATA_WIDTH_DEF
) (
  input logic            clk,
  input logic            rst,
  rf_read_sched_if.slave bus
);

  state_t                state_q;
  state_t                state_d;
  logic [ADDR_WIDTH-1:0] rs1_q;
  logic [ADDR_WIDTH-1:0] rs2_q;
  logic [ADDR_WIDTH-1:0] raddr;
  logic [DATA_WIDTH-1:0] op1_q;
  logic [DATA_WIDTH-1:0] op2_q;
  logic [DATA_WIDTH-1:0] cap_val;
  logic                  hazard;
  logic                  accept;
  logic                  same_src;

`ifdef RF_SCOREBOARD_EN
  rf_scoreboard #(
    .ADDR_WIDTH (ADDR_WIDTH)
  ) u_scoreboard (
    .clk        (clk),
    .rst        (rst),
    .set_en     (accept && bus.req_rd_wen && (bus.req_rd != '0)),
    .set_addr   (bus.req_rd),
    .clr_en     (bus.wb_en),
    .clr_addr   (bus.wb_addr),
    .chk_rs1    (bus.req_rs1),
    .chk_rs2    (bus.req_rs2),
    .chk_rd     (bus.req_rd),
    .chk_rd_wen (bus.req_rd_wen),
    .hazard     (hazard)
  );
`else
  // Without the scoreboard the destination fields carry no information for this block.
  logic unused_req_rd;
  assign unused_req_rd = ^{bus.req_rd, bus.req_rd_wen};
  assign hazard        = 1'b0;
`endif

  assign same_src      = (rs1_q == rs2_q);
  assign accept        = (state_q == IDLE) && bus.req_valid && !hazard;
  assign bus.req_ready = (state_q == IDLE) && !hazard;
  assign bus.out_valid = (state_q == RESP);
  assign bus.out_rs1_data = op1_q;
  assign bus.out_rs2_data = op2_q;
  assign bus.rf_raddr  = raddr;

  // Write port is a straight pass-through; the register file itself drops x0 writes.
  assign bus.rf_wen   = bus.wb_en;
  assign bus.rf_waddr = bus.wb_addr;
  assign bus.rf_wdata = bus.wb_data;

  // Read address follows the state: rs1 in RD1, rs2 in RD2, parked at 0 otherwise.
  always_comb begin
    raddr = '0;
    case (state_q)
      RD1:     raddr = rs1_q;
      RD2:     raddr = rs2_q;
      default: raddr = '0;
    endcase
  end

  // Operand value: x0 is zero, a same-cycle writeback to the address beats the stale read data.
  always_comb begin
    cap_val = bus.rf_rdata;
    if (raddr == '0)
      cap_val = '0;
    else if (bus.wb_en && (bus.wb_addr == raddr))
      cap_val = bus.wb_data;
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // Next state: skip the second read when both sources name the same register.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (accept) state_d = RD1;
      RD1:     state_d = same_src ? RESP : RD2;
      RD2:     state_d = RESP;
      RESP:    if (bus.out_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Latch source addresses on accept and capture operands during the read states.
  always_ff @(posedge clk) begin
    if (rst) begin
      rs1_q <= '0;
      rs2_q <= '0;
      op1_q <= '0;
      op2_q <= '0;
    end else begin
      if (accept) begin
        rs1_q <= bus.req_rs1;
        rs2_q <= bus.req_rs2;
      end
      if (state_q == RD1) begin
        op1_q <= cap_val;
        if (same_src) op2_q <= cap_val;
      end
      if (state_q == RD2) op2_q <= cap_val;
    end
  end

endmodule
